cpu_obi_arbiter: RTL and testbench

CPU_OBI_ARBITER -- requirements
Module: cpu_obi_arbiter

---
 rtl/cpu_obi_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cpu_obi_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cpu_obi_arbiter.sv
// Two-requester OBI arbiter (instruction = ID 0, data = ID 1) sharing one downstream port.
// An in-order ID FIFO tracks granted transactions and routes each rvalid back to its owner.
// Each OBI struct is carried as a packed vector:
//   request  [69:0] = {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   response [33:0] = {gnt, rvalid, rdata[31:0]}
module cpu_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [69:0] core_instr_req_i,
    output logic [33:0] core_instr_resp_o,
    input  logic [69:0] core_data_req_i,
    output logic [33:0] core_data_resp_o,
    output logic [69:0] mem_req_o,
    input  logic [33:0] mem_resp_i,
    output logic [2:0]  outstanding_o,
    output logic        err_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wait_id;
    logic        r_prio;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        r_fifo [0:3];

    logic        w_instr_act;
    logic        w_data_act;
    logic        w_full;
    logic        w_empty;
    logic        w_sel_valid;
    logic        w_sel_id;
    logic        w_req;
    logic        w_gnt_in;
    logic        w_rvalid_in;
    logic        w_push;
    logic        w_pop;
    logic        w_head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == 2'(MAX_OUTSTANDING - 1)) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    assign w_instr_act = core_instr_req_i[69];
    assign w_data_act  = core_data_req_i[69];
    assign w_gnt_in    = mem_resp_i[33];
    assign w_rvalid_in = mem_resp_i[32];
    assign w_full      = (r_count == 3'(MAX_OUTSTANDING));
    assign w_empty     = (r_count == 3'd0);
    assign w_head      = r_fifo[r_rptr];

    // Requester selection: fresh arbitration in IDLE, locked to the latched ID in WAIT_GNT.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_full) begin
                    w_sel_valid = 1'b0;
                    w_sel_id    = 1'b0;
                end else if (w_instr_act && w_data_act) begin
                    w_sel_valid = 1'b1;
                    w_sel_id    = r_prio;
                end else if (w_data_act) begin
                    w_sel_valid = 1'b1;
                    w_sel_id    = 1'b1;
                end else if (w_instr_act) begin
                    w_sel_valid = 1'b1;
                    w_sel_id    = 1'b0;
                end else begin
                    w_sel_valid = 1'b0;
                    w_sel_id    = 1'b0;
                end
            end
            WAIT_GNT: begin
                // Gated by the owner's own req so a grant can never reach an idle requester.
                w_sel_valid = r_wait_id ? w_data_act : w_instr_act;
                w_sel_id    = r_wait_id;
            end
            default: begin
                w_sel_valid = 1'b0;
                w_sel_id    = 1'b0;
            end
        endcase
    end

    assign w_req  = w_sel_valid & ~rst_i;
    assign w_push = w_req & w_gnt_in;
    assign w_pop  = w_rvalid_in & ~w_empty & ~rst_i;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req && !w_gnt_in) begin
                    w_state_nxt = WAIT_GNT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_GNT: begin
                if (!w_req || w_gnt_in) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_GNT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Downstream request mux.
    always_comb begin
        mem_req_o = 70'd0;
        if (w_req) begin
            mem_req_o = w_sel_id ? core_data_req_i : core_instr_req_i;
        end else begin
            mem_req_o = 70'd0;
        end
    end

    assign core_instr_resp_o = {w_push & ~w_sel_id, w_pop & ~w_head, mem_resp_i[31:0]};
    assign core_data_resp_o  = {w_push &  w_sel_id, w_pop &  w_head, mem_resp_i[31:0]};
    assign err_o             = w_rvalid_in & w_empty & ~rst_i;
    assign outstanding_o     = rst_i ? 3'd0 : r_count;

    // Control state: FSM, latched ID, priority pointer, FIFO pointers and count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_wait_id <= 1'b0;
            r_prio    <= 1'b1;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
            r_count   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_state_nxt == WAIT_GNT) begin
                r_wait_id <= w_sel_id;
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
                r_prio <= ~w_sel_id;
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ID storage; validity is tracked by the pointers and count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_sel_id;
        end
    end

endmodule

// File: tb/tb_cpu_obi_arbiter.sv
// Directed, table-driven bench for cpu_obi_arbiter (MAX_OUTSTANDING = 2).
// Each vector is one clock cycle: inputs driven at negedge, combinational outputs checked before posedge.
module tb_cpu_obi_arbiter;

    typedef struct {
        logic       rst;
        logic       ir;
        logic       dr;
        logic       g;
        logic       rv;
        logic       ereq;
        logic       esel;
        logic       eig;
        logic       edg;
        logic       eirv;
        logic       edrv;
        logic       eerr;
        logic [2:0] eout;
    } vec_t;

    localparam logic [68:0] I_FLD = {1'b0, 4'hF, 32'h0000_1000, 32'h0000_0000};
    localparam logic [68:0] D_FLD = {1'b1, 4'h3, 32'h8000_2000, 32'hDEAD_BEEF};

    logic        clk;
    logic        rst_i;
    logic [69:0] instr_req;
    logic [33:0] instr_resp;
    logic [69:0] data_req;
    logic [33:0] data_resp;
    logic [69:0] mem_req;
    logic [33:0] mem_resp;
    logic [2:0]  outstanding;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl [0:17];

    cpu_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .core_instr_req_i (instr_req),
        .core_instr_resp_o(instr_resp),
        .core_data_req_i  (data_req),
        .core_data_resp_o (data_resp),
        .mem_req_o        (mem_req),
        .mem_resp_i       (mem_resp),
        .outstanding_o    (outstanding),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t V(input logic rst, ir, dr, g, rv, ereq, esel, eig, edg, eirv, edrv, eerr,
                               input logic [2:0] eout);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.g = g; v.rv = rv;
        v.ereq = ereq; v.esel = esel; v.eig = eig; v.edg = edg;
        v.eirv = eirv; v.edrv = edrv; v.eerr = eerr; v.eout = eout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] rd;
        logic [69:0] exp_mem;
        @(negedge clk);
        rd        = $urandom;
        rst_i     = v.rst;
        instr_req = {v.ir, I_FLD};
        data_req  = {v.dr, D_FLD};
        mem_resp  = {v.g, v.rv, rd};
        #2;
        exp_mem = v.ereq ? (v.esel ? {1'b1, D_FLD} : {1'b1, I_FLD}) : 70'd0;
        chk({nm, ".mem_req"}, mem_req, exp_mem);
        chk({nm, ".instr_resp"}, {36'd0, instr_resp}, {36'd0, v.eig, v.eirv, rd});
        chk({nm, ".data_resp"}, {36'd0, data_resp}, {36'd0, v.edg, v.edrv, rd});
        chk({nm, ".err"}, {69'd0, err}, {69'd0, v.eerr});
        chk({nm, ".outstanding"}, {67'd0, outstanding}, {67'd0, v.eout});
    endtask

    initial begin
        rst_i     = 1'b1;
        instr_req = 70'd0;
        data_req  = 70'd0;
        mem_resp  = 34'd0;

        //          rst ir dr g  rv  req sel ig dg irv drv err out
        tbl[0]  = V(0, 0, 0, 0, 0,   0,  0,  0, 0, 0,  0,  0,  3'd0);
        tbl[1]  = V(0, 1, 1, 1, 0,   1,  1,  0, 1, 0,  0,  0,  3'd0); // pointer starts at data
        tbl[2]  = V(0, 1, 1, 1, 1,   1,  0,  1, 0, 0,  1,  0,  3'd1); // grant+rvalid at count 1
        tbl[3]  = V(0, 1, 1, 1, 1,   1,  1,  0, 1, 1,  0,  0,  3'd1);
        tbl[4]  = V(0, 1, 1, 1, 0,   1,  0,  1, 0, 0,  0,  0,  3'd1);
        tbl[5]  = V(0, 1, 1, 1, 0,   0,  0,  0, 0, 0,  0,  0,  3'd2); // full
        tbl[6]  = V(0, 1, 1, 1, 1,   0,  0,  0, 0, 0,  1,  0,  3'd2); // full, pop gives no bypass
        tbl[7]  = V(0, 1, 1, 1, 0,   1,  1,  0, 1, 0,  0,  0,  3'd1);
        tbl[8]  = V(0, 0, 0, 0, 1,   0,  0,  0, 0, 1,  0,  0,  3'd2);
        tbl[9]  = V(0, 0, 0, 0, 1,   0,  0,  0, 0, 0,  1,  0,  3'd1);
        tbl[10] = V(0, 0, 0, 0, 1,   0,  0,  0, 0, 0,  0,  1,  3'd0); // stray rvalid
        tbl[11] = V(0, 0, 0, 0, 0,   0,  0,  0, 0, 0,  0,  0,  3'd0);
        tbl[12] = V(0, 0, 1, 0, 0,   1,  1,  0, 0, 0,  0,  0,  3'd0); // enter WAIT_GNT on data
        tbl[13] = V(0, 1, 1, 0, 0,   1,  1,  0, 0, 0,  0,  0,  3'd0); // locked although pointer=instr
        tbl[14] = V(0, 1, 1, 1, 0,   1,  1,  0, 1, 0,  0,  0,  3'd0);
        tbl[15] = V(0, 1, 0, 1, 0,   1,  0,  1, 0, 0,  0,  0,  3'd1);
        tbl[16] = V(0, 0, 0, 0, 1,   0,  0,  0, 0, 0,  1,  0,  3'd2);
        tbl[17] = V(0, 0, 0, 0, 1,   0,  0,  0, 0, 1,  0,  0,  3'd1);

        // Reset with all inputs active: everything quiet.
        run_vec(V(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0), "reset0");
        run_vec(V(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0), "reset1");

        for (int i = 0; i < 18; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Instr stalls three cycles; data rising meanwhile must wait (pointer favours data).
        run_vec(V(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0), "stall_a");
        run_vec(V(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0), "stall_b");
        run_vec(V(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0), "stall_c");
        run_vec(V(0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'd0), "stall_gnt");
        run_vec(V(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 3'd1), "stall_data");
        run_vec(V(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3'd2), "stall_rv0");
        run_vec(V(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'd1), "stall_rv1");

        // Reset with two outstanding, then a stray rvalid.
        run_vec(V(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'd0), "mrst_g0");
        run_vec(V(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'd1), "mrst_g1");
        run_vec(V(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2), "mrst_full");
        run_vec(V(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0), "mrst_rst");
        run_vec(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "mrst_after");
        run_vec(V(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3'd0), "mrst_stray");
        run_vec(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0), "mrst_quiet");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
